// File: rtl/adder_operand_stager_if.sv
// Operand/result handshake bundle between the stager, its producer/consumer
// and the external Brent-Kung adder.
interface adder_operand_stager_if #(
  parameter int W     = 12,
  parameter int DEPTH = 2
);
  localparam int OW = $clog2(DEPTH + 3);

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic [2*W-1:0] add_in;
  logic [W:0]     add_sum;
  logic           out_valid;
  logic           out_ready;
  logic [W:0]     out_sum;
  logic [OW-1:0]  occupancy;
  logic           busy;

  modport slave (
    input  in_valid, in_a, in_b, add_sum, out_ready,
    output in_ready, add_in, out_valid, out_sum, occupancy, busy
  );

  modport master (
    output in_valid, in_a, in_b, add_sum, out_ready,
    input  in_ready, add_in, out_valid, out_sum, occupancy, busy
  );
endinterface

// File: rtl/adder_operand_stager.sv
// Valid/ready front end for the 12-bit Brent-Kung adder: operand FIFO ->
// op register driving the interleaved adder bus -> registered sum.
module adder_operand_stager #(
  parameter int W     = 12,
  parameter int DEPTH = 2
) (
  input logic                   clk,
  input logic                   rst,
  adder_operand_stager_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(DEPTH + 3);

  logic [W-1:0]  fifo_a_q [DEPTH];
  logic [W-1:0]  fifo_a_d [DEPTH];
  logic [W-1:0]  fifo_b_q [DEPTH];
  logic [W-1:0]  fifo_b_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          op_valid_q, op_valid_d;
  logic [W-1:0]  op_a_q, op_a_d;
  logic [W-1:0]  op_b_q, op_b_d;
  logic          out_valid_q, out_valid_d;
  logic [W:0]    out_sum_q, out_sum_d;

  logic           in_ready, push, pop, res_adv, op_adv;
  logic [2*W-1:0] add_in;

  always_comb begin
    // Full FIFO blocks input even if it pops this cycle; keeps in_ready off out_ready.
    in_ready = (count_q < CW'(DEPTH));
    push     = bus.in_valid & in_ready;
    res_adv  = op_valid_q & (~out_valid_q | bus.out_ready);
    op_adv   = ~op_valid_q | res_adv;
    pop      = op_adv & (count_q != '0);

    fifo_a_d = fifo_a_q;
    fifo_b_d = fifo_b_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_a_d[wr_ptr_q] = bus.in_a;
      fifo_b_d[wr_ptr_q] = bus.in_b;
      wr_ptr_d           = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);

    op_valid_d = op_valid_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    if (op_adv) begin
      op_valid_d = pop;
      if (pop) begin
        op_a_d = fifo_a_q[rd_ptr_q];
        op_b_d = fifo_b_q[rd_ptr_q];
      end
    end

    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    if (res_adv) begin
      out_valid_d = 1'b1;
      out_sum_d   = bus.add_sum;
    end else if (bus.out_ready & out_valid_q) begin
      out_valid_d = 1'b0;
    end

    // Bus is forced to zero while the op stage is empty so the adder stays quiet.
    add_in = '0;
    for (int i = 0; i < W; i++) begin
      add_in[2*i]   = op_valid_q & op_a_q[i];
      add_in[2*i+1] = op_valid_q & op_b_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_a_q[i] <= '0;
        fifo_b_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      op_valid_q  <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
    end else begin
      fifo_a_q    <= fifo_a_d;
      fifo_b_q    <= fifo_b_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      op_valid_q  <= op_valid_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.add_in    = add_in;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.occupancy = OW'(count_q) + OW'(op_valid_q) + OW'(out_valid_q);
  assign bus.busy      = (count_q != '0) | op_valid_q | out_valid_q;
endmodule
